// File: rtl/instr_fetch_ctrl.sv
// Fetch/branch controller: decodes ROM words and drives the program counter's
// jump, branch and hold requests, and issues datapath ops with a one-cycle valid pulse.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               fetch_reset_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero_flag,
  output logic               jmp,
  output logic               ban,
  output logic [ADDR_W-1:0]  addrJmp,
  output logic               stop,
  output logic [INSTR_W-1:0] ir,
  output logic               alu_valid,
  output logic [CNT_W-1:0]   icount
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_FLUSH,
    ST_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BRZ  = 4'h2;
  localparam logic [3:0] OP_BRNZ = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e             state_q;
  logic               jmp_q;
  logic               ban_q;
  logic               alu_valid_q;
  logic               stop_q;
  logic [ADDR_W-1:0]  addr_jmp_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   icount_q;
  logic [CNT_W-1:0]   icount_d;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  operand;

  assign opcode  = instr[INSTR_W-1 -: 4];
  assign operand = instr[ADDR_W-1:0];

  // The PC forms the branch target from its own address, so addr is not needed here.
  logic unused_addr;
  assign unused_addr = ^addr;

  // Retired count sticks at all-ones instead of wrapping.
  assign icount_d = (icount_q == '1) ? icount_q : icount_q + 1'b1;

  // NOTE: every state/output register below is updated with non-blocking
  // assignments so all of them see the same pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (!fetch_reset_n) begin
      state_q     <= ST_IDLE;
      jmp_q       <= 1'b0;
      ban_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      stop_q      <= 1'b1;
      addr_jmp_q  <= '0;
      ir_q        <= '0;
      icount_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q <= ST_FETCH;
            stop_q  <= 1'b0;
          end
        end

        ST_FETCH: begin
          ir_q        <= instr;
          state_q     <= ST_EXEC;
          stop_q      <= 1'b0;
          jmp_q       <= 1'b0;
          ban_q       <= 1'b0;
          alu_valid_q <= 1'b0;
          addr_jmp_q  <= '0;
          case (opcode)
            OP_NOP: ;
            OP_JMP: begin
              jmp_q      <= 1'b1;
              addr_jmp_q <= operand;
            end
            OP_BRZ: begin
              if (zero_flag) begin
                ban_q      <= 1'b1;
                addr_jmp_q <= operand;
              end
            end
            OP_BRNZ: begin
              if (!zero_flag) begin
                ban_q      <= 1'b1;
                addr_jmp_q <= operand;
              end
            end
            OP_HALT: begin
              state_q  <= ST_HALT;
              stop_q   <= 1'b1;
              icount_q <= icount_d;
            end
            default: alu_valid_q <= 1'b1;
          endcase
        end

        ST_EXEC: begin
          jmp_q       <= 1'b0;
          ban_q       <= 1'b0;
          alu_valid_q <= 1'b0;
          addr_jmp_q  <= '0;
          icount_q    <= icount_d;
          // A taken jump/branch needs one bubble while the PC loads its new address.
          if (jmp_q || ban_q) begin
            state_q <= ST_FLUSH;
            stop_q  <= 1'b0;
          end else if (run) begin
            state_q <= ST_FETCH;
            stop_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b1;
          end
        end

        ST_FLUSH: begin
          if (run) begin
            state_q <= ST_FETCH;
            stop_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            stop_q  <= 1'b1;
          end
        end

        ST_HALT: begin
          stop_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          stop_q  <= 1'b1;
        end
      endcase
    end
  end

  assign jmp       = jmp_q;
  assign ban       = ban_q;
  assign addrJmp   = addr_jmp_q;
  assign stop      = stop_q;
  assign ir        = ir_q;
  assign alu_valid = alu_valid_q;
  assign icount    = icount_q;

endmodule
